// File: rtl/inv_subst_engine.sv
// -----------------------------------------------------------------------------
// inv_subst_engine
//
// Builds the inverse of an 8-bit byte substitution table, then answers inverse
// lookups. A start pulse launches a single 256-cycle sweep of the external
// forward table and writes each entry into the local inverse table. When
// CHECK_BIJECTION=1, a repeated forward output is flagged and the sweep ends in
// FAULT rather than READY. In READY, lookups are accepted over a valid/ready
// port and answered one cycle later, one lookup per cycle.
//
// States:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | after reset; no table; waiting for start
//   BUILD   | sweeping fwd table, one entry per cycle (idx 0..255)
//   READY   | inverse table valid; lookups accepted; start rebuilds
//   FAULT   | forward table was not a bijection; waiting for start
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a build (ignored during BUILD)
//   fwd_addr / fwd_data  combinational read port into the forward table
//   busy                 high in BUILD
//   table_ok             high in READY
//   fault                high in FAULT
//   req_valid/req_ready  lookup request handshake; req_data is the byte to invert
//   rsp_valid/rsp_data   one-cycle response pulse and inverse byte
// -----------------------------------------------------------------------------
module inv_subst_engine #(
    parameter bit CHECK_BIJECTION = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] fwd_addr,
    input  logic [7:0] fwd_data,
    output logic       busy,
    output logic       table_ok,
    output logic       fault,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUILD = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [7:0]   idx;
    logic [255:0] seen;
    logic         dup;
    logic [7:0]   inv_mem [0:255];

    logic in_build;
    logic last_idx;
    logic dup_hit;
    logic hs;

    assign in_build = (state == S_BUILD);
    assign last_idx = (idx == 8'hff);
    // With the check disabled this folds to 0 and the seen/dup logic is pruned.
    assign dup_hit  = CHECK_BIJECTION && seen[fwd_data];
    assign hs       = req_valid && (state == S_READY);

    // ---------------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUILD;
            S_BUILD: begin
                // The final write's own duplicate counts toward the verdict.
                if (last_idx)
                    state_nxt = (dup || dup_hit) ? S_FAULT : S_READY;
            end
            S_READY: if (start) state_nxt = S_BUILD;
            S_FAULT: if (start) state_nxt = S_BUILD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control state, sweep index and bijection tracking
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= 8'h00;
            seen  <= '0;
            dup   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_build) begin
                seen[fwd_data] <= 1'b1;
                if (dup_hit)
                    dup <= 1'b1;
                // Hold at 255 so the sweep never starts a second pass.
                if (!last_idx)
                    idx <= idx + 8'd1;
            end else if (start) begin
                idx  <= 8'h00;
                seen <= '0;
                dup  <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Inverse table storage; deliberately not reset, only trusted in READY
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_build)
            inv_mem[fwd_data] <= idx;
    end

    // ---------------------------------------------------------------------
    // Lookup response. A request accepted in the same cycle as a rebuild
    // start still reads the old table, since the first BUILD write lands on
    // the following edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= hs;
            if (hs)
                rsp_data <= inv_mem[req_data];
        end
    end

    assign busy      = in_build;
    assign table_ok  = (state == S_READY);
    assign fault     = (state == S_FAULT);
    assign req_ready = table_ok;
    assign fwd_addr  = in_build ? idx : 8'h00;

endmodule

// File: tb/tb_inv_subst_engine.sv
module tb_inv_subst_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] fwd_addr;
    logic [7:0] fwd_data;
    logic       busy;
    logic       table_ok;
    logic       fault;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    int n_cmp;
    int n_err;

    logic [7:0] fwd   [256];
    logic [7:0] built [256];
    logic [7:0] exp_rd;

    inv_subst_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .busy      (busy),
        .table_ok  (table_ok),
        .fault     (fault),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward table model: combinational read.
    always_comb fwd_data = fwd[fwd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Inverse by search over the table that was built: last writer wins.
    function automatic logic [7:0] model_inv(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int x = 0; x < 256; x++)
            if (built[x] == v) r = 8'(x);
        return r;
    endfunction

    function automatic logic has_dup();
        int cnt [256];
        logic d;
        d = 1'b0;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        for (int i = 0; i < 256; i++) cnt[fwd[i]]++;
        for (int i = 0; i < 256; i++) if (cnt[i] > 1) d = 1'b1;
        return d;
    endfunction

    task automatic make_perm(input logic pin_first);
        logic [7:0] t;
        logic [7:0] pins [3];
        int j;
        for (int i = 0; i < 256; i++) fwd[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = fwd[i]; fwd[i] = fwd[j]; fwd[j] = t;
        end
        if (pin_first) begin
            pins[0] = 8'hb3; pins[1] = 8'h1a; pins[2] = 8'h5f;
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 256; p++)
                    if (fwd[p] == pins[k]) begin
                        t = fwd[k]; fwd[k] = fwd[p]; fwd[p] = t;
                    end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_table_ok"},  32'(table_ok),  32'd0);
        chk({tag, "_fault"},     32'(fault),     32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'h00);
        chk({tag, "_fwd_addr"},  32'(fwd_addr),  32'h00);
    endtask

    // Launch a build and follow it to completion. abort_at / pulse_at select
    // the build cycle (0-based) for a reset or a stray start; -1 disables.
    task automatic do_build(input int abort_at, input int pulse_at,
                            input logic with_req, input logic [7:0] req_byte);
        int   cnt;
        logic exp_fault;
        exp_fault = has_dup();
        start = 1'b1;
        if (with_req) begin
            req_valid = 1'b1;
            req_data  = req_byte;
        end
        step;
        start     = 1'b0;
        req_valid = 1'b0;
        if (with_req) begin
            exp_rd = model_inv(req_byte);
            chk("rebuild_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rebuild_rsp_data",  32'(rsp_data),  32'(exp_rd));
        end
        chk("build_busy_first", 32'(busy), 32'd1);
        chk("build_ready_low",  32'(req_ready), 32'd0);
        cnt = 0;
        while (busy && cnt < 400) begin
            chk("build_fwd_addr", 32'(fwd_addr), 32'(cnt & 255));
            if (cnt == abort_at) begin
                rst = 1'b1;
                #1;
                exp_rd = 8'h00;
                chk_reset_outputs("abort");
                repeat (2) @(posedge clk);
                #3 rst = 1'b0;
                step;
                chk_reset_outputs("after_abort");
                return;
            end
            if (cnt == pulse_at) start = 1'b1;
            step;
            start = 1'b0;
            if (busy) chk("build_req_ready", 32'(req_ready), 32'd0);
            cnt++;
        end
        chk("build_len",      32'(cnt),       32'd256);
        chk("build_fault",    32'(fault),     32'(exp_fault));
        chk("build_table_ok", 32'(table_ok),  32'(!exp_fault));
        chk("build_ready",    32'(req_ready), 32'(!exp_fault));
        chk("idle_fwd_addr",  32'(fwd_addr),  32'h00);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 256; i++) built[i] = fwd[i];
    endtask

    // Random request traffic; ready_exp says whether the block should accept.
    task automatic random_lookups(input int n, input logic ready_exp);
        logic       v;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            v = 1'($urandom_range(1, 0));
            d = 8'($urandom);
            req_valid = v;
            req_data  = d;
            step;
            if (v && ready_exp) exp_rd = model_inv(d);
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(v && ready_exp));
            chk("rnd_rsp_data",  32'(rsp_data),  32'(exp_rd));
        end
        req_valid = 1'b0;
        step;
        chk("rnd_rsp_idle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_rd    = 8'h00;
        rst       = 1'b1;
        start     = 1'b0;
        req_valid = 1'b0;
        req_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            fwd[i]   = 8'(i);
            built[i] = 8'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #3 rst = 1'b0;
        step;
        chk_reset_outputs("idle");

        // Requests in IDLE are not accepted.
        random_lookups(8, 1'b0);

        // Build with pinned first three entries.
        make_perm(1'b1);
        do_build(-1, -1, 1'b0, 8'h00);

        // Three consecutive lookups.
        req_valid = 1'b1;
        req_data  = 8'hb3;
        step;
        chk("lk0_valid", 32'(rsp_valid), 32'd1);
        chk("lk0_data",  32'(rsp_data),  32'h00);
        req_data = 8'h1a;
        step;
        chk("lk1_valid", 32'(rsp_valid), 32'd1);
        chk("lk1_data",  32'(rsp_data),  32'h01);
        req_data = 8'h5f;
        step;
        chk("lk2_valid", 32'(rsp_valid), 32'd1);
        chk("lk2_data",  32'(rsp_data),  32'h02);
        exp_rd = 8'h02;

        // Exhaustive round trip under continuous req_valid.
        for (int x = 0; x < 256; x++) begin
            req_data = fwd[x];
            step;
            chk("rt_valid", 32'(rsp_valid), 32'd1);
            chk("rt_data",  32'(rsp_data),  32'(x));
        end
        exp_rd = 8'hff;
        req_valid = 1'b0;
        step;
        chk("rt_end_valid", 32'(rsp_valid), 32'd0);
        chk("rt_hold_data", 32'(rsp_data),  32'hff);

        random_lookups(60, 1'b1);

        // Non-bijective table: entries 5 and 9 both map to 0x53.
        make_perm(1'b0);
        fwd[5] = 8'h53;
        fwd[9] = 8'h53;
        do_build(-1, -1, 1'b0, 8'h00);
        chk("dup_fault", 32'(fault), 32'd1);
        random_lookups(10, 1'b0);

        // Corrected table recovers.
        make_perm(1'b1);
        do_build(-1, -1, 1'b0, 8'h00);
        chk("recover_ok", 32'(table_ok), 32'd1);
        random_lookups(20, 1'b1);

        // Reset at build cycle 100, then a full rebuild.
        make_perm(1'b0);
        do_build(100, -1, 1'b0, 8'h00);
        do_build(-1, -1, 1'b0, 8'h00);
        random_lookups(20, 1'b1);

        // Rebuild from READY with a simultaneous 0xb3 request against the
        // pinned table, into a fresh random table.
        make_perm(1'b1);
        do_build(-1, -1, 1'b0, 8'h00);
        make_perm(1'b0);
        do_build(-1, -1, 1'b1, 8'hb3);
        chk("rebuild_old_b3", 32'(exp_rd), 32'h00);
        random_lookups(40, 1'b1);

        // Stray start during BUILD at cycle 50 has no effect on length.
        make_perm(1'b0);
        do_build(-1, 50, 1'b0, 8'h00);
        random_lookups(40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
